// File: rtl/fetch_if.sv
// Bundle between the fetch unit and its pipeline/instruction-memory neighbours.
// No valid/ready handshake here: redirect_pc is meaningful only in a cycle with redirect_valid=1, and imem_data must answer imem_addr in the same cycle.
interface fetch_if;
  logic        data_hazard;
  logic        control_hazard;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic        id_valid;
  logic [1:0]  fetch_state;
  logic [15:0] stall_count;

  modport master (
    output data_hazard, control_hazard, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, id_instr, id_pc_plus1, id_valid, fetch_state, stall_count
  );

  modport slave (
    input  data_hazard, control_hazard, redirect_valid, redirect_pc, imem_data,
    output imem_addr, id_instr, id_pc_plus1, id_valid, fetch_state, stall_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and a hold/squash FSM.
// One action per cycle, priority redirect > hold > squash > advance.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] BUBBLE   = 16'h0000
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic        id_valid;
  logic [15:0] stall_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      id_instr    <= BUBBLE;
      id_pc_plus1 <= 16'h0000;
      id_valid    <= 1'b0;
      state       <= ST_RUN;
      stall_count <= 16'h0000;
    end else if (bus.redirect_valid) begin
      // Redirect cycles are not counted as stalls.
      pc          <= bus.redirect_pc;
      id_instr    <= BUBBLE;
      id_pc_plus1 <= 16'h0000;
      id_valid    <= 1'b0;
      state       <= ST_SQUASH;
    end else if (bus.data_hazard) begin
      // Hold beats squash so the instruction sitting in ID is never lost.
      state <= ST_HOLD;
      if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end else if (bus.control_hazard) begin
      id_instr <= BUBBLE;
      id_valid <= 1'b0;
      state    <= ST_SQUASH;
      if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end else begin
      id_instr    <= bus.imem_data;
      id_pc_plus1 <= pc + 16'd1;
      id_valid    <= 1'b1;
      pc          <= pc + 16'd1;
      state       <= ST_RUN;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.id_instr    = id_instr;
  assign bus.id_pc_plus1 = id_pc_plus1;
  assign bus.id_valid    = id_valid;
  assign bus.fetch_state = state;
  assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus hand-written reset and saturation sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(16'h0000), .BUBBLE(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory model: word = 16'h1000 + address unless a fixed word is forced.
  logic        fix_en   = 1'b0;
  logic [15:0] fix_word = 16'h0000;
  assign bus.imem_data = fix_en ? fix_word : 16'(16'h1000 + bus.imem_addr);

  int tests  = 0;
  int failed = 0;
  logic [66:0] exp_q[$];

  typedef struct {
    string       name;
    logic        dh, ch, rv;
    logic [15:0] rpc;
    logic        fix;
    logic [15:0] word;
    logic [15:0] e_pc, e_instr, e_pp1;
    logic        e_valid;
    logic [1:0]  e_state;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [66:0] pack(logic [15:0] pc, logic [15:0] instr, logic [15:0] pp1,
                                       logic valid, logic [1:0] st, logic [15:0] stall);
    return {pc, instr, pp1, valid, st, stall};
  endfunction

  task automatic drive(input logic rst, input logic dh, input logic ch, input logic rv,
                       input logic [15:0] rpc, input logic fix, input logic [15:0] word);
    @(negedge clk);
    rst_n              = rst;
    bus.data_hazard    = dh;
    bus.control_hazard = ch;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    fix_en             = fix;
    fix_word           = word;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    logic [66:0] got;
    logic [66:0] e;
    got = pack(bus.imem_addr, bus.id_instr, bus.id_pc_plus1, bus.id_valid,
               bus.fetch_state, bus.stall_count);
    e = exp_q.pop_front();
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL %s: got pc=%h instr=%h pp1=%h valid=%b state=%0d stall=%h, expected pc=%h instr=%h pp1=%h valid=%b state=%0d stall=%h",
               name, got[66:51], got[50:35], got[34:19], got[18], got[17:16], got[15:0],
               e[66:51], e[50:35], e[34:19], e[18], e[17:16], e[15:0]);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic dh, input logic ch,
                      input logic rv, input logic [15:0] rpc, input logic fix,
                      input logic [15:0] word, input logic [66:0] exp_v);
    exp_q.push_back(exp_v);
    drive(rst, dh, ch, rv, rpc, fix, word);
    check(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //           name          dh  ch  rv  rpc      fix word     pc       instr    pp1      v  st stall
    vecs[0]  = '{"adv0",       0,  0,  0,  16'h0,    0, 16'h0,    16'h0001, 16'h1000, 16'h0001, 1, 0, 16'h0};
    vecs[1]  = '{"adv1",       0,  0,  0,  16'h0,    0, 16'h0,    16'h0002, 16'h1001, 16'h0002, 1, 0, 16'h0};
    vecs[2]  = '{"adv2",       0,  0,  0,  16'h0,    0, 16'h0,    16'h0003, 16'h1002, 16'h0003, 1, 0, 16'h0};
    vecs[3]  = '{"adv3",       0,  0,  0,  16'h0,    0, 16'h0,    16'h0004, 16'h1003, 16'h0004, 1, 0, 16'h0};
    vecs[4]  = '{"adv_a123",   0,  0,  0,  16'h0,    1, 16'hA123, 16'h0005, 16'hA123, 16'h0005, 1, 0, 16'h0};
    vecs[5]  = '{"hold1",      1,  0,  0,  16'h0,    0, 16'h0,    16'h0005, 16'hA123, 16'h0005, 1, 1, 16'h1};
    vecs[6]  = '{"hold2",      1,  0,  0,  16'h0,    0, 16'h0,    16'h0005, 16'hA123, 16'h0005, 1, 1, 16'h2};
    vecs[7]  = '{"adv_after",  0,  0,  0,  16'h0,    0, 16'h0,    16'h0006, 16'h1005, 16'h0006, 1, 0, 16'h2};
    vecs[8]  = '{"adv_6",      0,  0,  0,  16'h0,    0, 16'h0,    16'h0007, 16'h1006, 16'h0007, 1, 0, 16'h2};
    vecs[9]  = '{"adv_7",      0,  0,  0,  16'h0,    0, 16'h0,    16'h0008, 16'h1007, 16'h0008, 1, 0, 16'h2};
    vecs[10] = '{"squash1",    0,  1,  0,  16'h0,    0, 16'h0,    16'h0008, 16'h0000, 16'h0008, 0, 2, 16'h3};
    vecs[11] = '{"squash2",    0,  1,  0,  16'h0,    0, 16'h0,    16'h0008, 16'h0000, 16'h0008, 0, 2, 16'h4};
    vecs[12] = '{"squash3",    0,  1,  0,  16'h0,    0, 16'h0,    16'h0008, 16'h0000, 16'h0008, 0, 2, 16'h5};
    vecs[13] = '{"redir40",    0,  0,  1,  16'h0040, 0, 16'h0,    16'h0040, 16'h0000, 16'h0000, 0, 2, 16'h5};
    vecs[14] = '{"adv40",      0,  0,  0,  16'h0,    0, 16'h0,    16'h0041, 16'h1040, 16'h0041, 1, 0, 16'h5};
    vecs[15] = '{"redir_all",  1,  1,  1,  16'h0020, 0, 16'h0,    16'h0020, 16'h0000, 16'h0000, 0, 2, 16'h5};
    vecs[16] = '{"hold_vs_sq", 1,  1,  0,  16'h0,    0, 16'h0,    16'h0020, 16'h0000, 16'h0000, 0, 1, 16'h6};
    vecs[17] = '{"adv20",      0,  0,  0,  16'h0,    0, 16'h0,    16'h0021, 16'h1020, 16'h0021, 1, 0, 16'h6};
    vecs[18] = '{"redirffff",  0,  0,  1,  16'hFFFF, 0, 16'h0,    16'hFFFF, 16'h0000, 16'h0000, 0, 2, 16'h6};
    vecs[19] = '{"wrap",       0,  0,  0,  16'h0,    0, 16'h0,    16'h0000, 16'h0FFF, 16'h0000, 1, 0, 16'h6};

    bus.data_hazard    = 1'b0;
    bus.control_hazard = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;

    step("reset", 1'b0, 0, 0, 1, 16'h1234, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0));

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].name, 1'b1, vecs[i].dh, vecs[i].ch, vecs[i].rv, vecs[i].rpc,
           vecs[i].fix, vecs[i].word,
           pack(vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp1, vecs[i].e_valid,
                vecs[i].e_state, vecs[i].e_stall));
    end

    // Reset in the middle of a hold discards the held instruction.
    step("reset2",    1'b0, 0, 0, 0, 16'h0, 0, 16'h0,    pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0));
    step("first_adv", 1'b1, 0, 0, 0, 16'h0, 0, 16'h0,    pack(16'h1, 16'h1000, 16'h1, 1'b1, 2'd0, 16'h0));
    step("adv_b456",  1'b1, 0, 0, 0, 16'h0, 1, 16'hB456, pack(16'h2, 16'hB456, 16'h2, 1'b1, 2'd0, 16'h0));
    step("hold_b456", 1'b1, 1, 0, 0, 16'h0, 0, 16'h0,    pack(16'h2, 16'hB456, 16'h2, 1'b1, 2'd1, 16'h1));
    step("rst_hold",  1'b0, 1, 1, 1, 16'h0077, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0));

    // Saturation: 65534 hold cycles reach FFFE, further stalls stick at FFFF.
    for (int i = 0; i < 65534; i++) drive(1'b1, 1, 0, 0, 16'h0, 0, 16'h0);
    exp_q.push_back(pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd1, 16'hFFFE));
    check("stall_fffe");
    step("sat1", 1'b1, 1, 0, 0, 16'h0, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd1, 16'hFFFF));
    step("sat2", 1'b1, 1, 0, 0, 16'h0, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd1, 16'hFFFF));
    step("sat3", 1'b1, 1, 0, 0, 16'h0, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd1, 16'hFFFF));
    step("sat_sq", 1'b1, 0, 1, 0, 16'h0, 0, 16'h0, pack(16'h0, 16'h0, 16'h0, 1'b0, 2'd2, 16'hFFFF));
    step("sat_adv", 1'b1, 0, 0, 0, 16'h0, 0, 16'h0, pack(16'h1, 16'h1000, 16'h1, 1'b1, 2'd0, 16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
